// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types, size encodings and error helper for the LSU.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    // Size/alignment error only; range checking depends on the memory depth.
    function automatic logic misalign_err(input logic [1:0] size, input logic [1:0] addr_lo);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = addr_lo[0];
            SZ_WORD: err = (addr_lo != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Pipeline request/response handshake bundle for the LSU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane_align
//  Description : Little-endian lane extract/extend for loads and lane merge
//                for sub-word stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        case (addr_lo)
            2'd0: w_byte = word[7:0];
            2'd1: w_byte = word[15:8];
            2'd2: w_byte = word[23:16];
            2'd3: w_byte = word[31:24];
            default: w_byte = word[7:0];
        endcase
        w_half = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_data = word;
        case (size)
            SZ_BYTE: load_data = {{24{is_signed & w_byte[7]}}, w_byte};
            SZ_HALF: load_data = {{16{is_signed & w_half[15]}}, w_half};
            default: load_data = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0: merged[7:0]   = wdata[7:0];
                    2'd1: merged[15:8]  = wdata[7:0];
                    2'd2: merged[23:16] = wdata[7:0];
                    2'd3: merged[31:24] = wdata[7:0];
                    default: merged = word;
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default: merged = wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Byte-addressed load/store front end for a word-addressed
//                memory, with read-modify-write for sub-word stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    load_store_unit_if.slave        bus,
    output logic [31:0]             mem_addr,
    output logic                    mem_wr_en,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata
);

    localparam logic [31:0] c_depth_limit = 32'(DEPTH_WORDS);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merged;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_req_err;
    logic        w_sub_store;
    logic [31:0] w_word_idx;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_accept    = bus.req_valid & (r_state == IDLE);
    assign w_req_err   = misalign_err(bus.req_size, bus.req_addr[1:0])
                       | ({2'b00, bus.req_addr[31:2]} >= c_depth_limit);
    assign w_sub_store = r_we & (r_size != SZ_WORD);
    assign w_word_idx  = {2'b00, r_addr[31:2]};

    lsu_lane_align u_lane_align (
        .word      (mem_rdata),
        .addr_lo   (r_addr[1:0]),
        .size      (r_size),
        .is_signed (r_signed),
        .wdata     (r_wdata),
        .load_data (w_load_data),
        .merged    (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory strobes are decoded from state so an async reset kills them at once.
    always_comb begin
        w_state_nxt   = r_state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        mem_addr      = 32'd0;
        mem_wr_en     = 1'b0;
        mem_wdata     = 32'd0;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = w_req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr = w_word_idx;
                if (r_we && !w_sub_store) begin
                    mem_wr_en = 1'b1;
                    mem_wdata = r_wdata;
                end
                w_state_nxt = w_sub_store ? WRITE : RESP;
            end
            WRITE: begin
                mem_addr    = w_word_idx;
                mem_wr_en   = 1'b1;
                mem_wdata   = r_merged;
                w_state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_size   <= 2'd0;
            r_signed <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_merged <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we     <= bus.req_we;
                        r_size   <= bus.req_size;
                        r_signed <= bus.req_signed;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_err    <= w_req_err;
                        r_rdata  <= 32'd0;
                    end
                end
                ACCESS: begin
                    if (!r_we) begin
                        r_rdata <= w_load_data;
                    end else if (w_sub_store) begin
                        r_merged <= w_merged;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

endmodule
`default_nettype wire
